// File: rtl/dds_uart_pkg.sv
// Shared types and constants for the DDS sine source and the UART transmitter.
package dds_uart_pkg;

    localparam int         DDS_QUARTER = 64;
    localparam logic [7:0] DAC_MID     = 8'd128;
    localparam logic [7:0] DAC_PEAK    = 8'd255;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    // 128 + round(127 * sin(2*pi*k/256)) for k = 0..63
    localparam logic [7:0] SINE_QUARTER [DDS_QUARTER] = '{
        8'd128, 8'd131, 8'd134, 8'd137, 8'd140, 8'd144, 8'd147, 8'd150,
        8'd153, 8'd156, 8'd159, 8'd162, 8'd165, 8'd168, 8'd171, 8'd174,
        8'd177, 8'd179, 8'd182, 8'd185, 8'd188, 8'd191, 8'd193, 8'd196,
        8'd199, 8'd201, 8'd204, 8'd206, 8'd209, 8'd211, 8'd213, 8'd216,
        8'd218, 8'd220, 8'd222, 8'd224, 8'd226, 8'd228, 8'd230, 8'd232,
        8'd234, 8'd235, 8'd237, 8'd239, 8'd240, 8'd241, 8'd243, 8'd244,
        8'd245, 8'd246, 8'd248, 8'd249, 8'd250, 8'd250, 8'd251, 8'd252,
        8'd253, 8'd253, 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255
    };

    // Quarter-wave lookup over 0..64; the peak at 64 lies just outside the table.
    function automatic logic [7:0] quarter_sample(input logic [6:0] m);
        if (m >= 7'(DDS_QUARTER)) begin
            return DAC_PEAK;
        end
        return SINE_QUARTER[m[5:0]];
    endfunction

endpackage

// File: rtl/dds_uart_tx_core_if.sv
// FIFO-to-UART handshake and serial line bundle.
interface dds_uart_tx_core_if;
    logic [7:0] din;
    logic       wr_en;
    logic       read_fifo_flag;
    logic       tx;
    logic       tx_busy;

    modport master (
        output din,
        output wr_en,
        input  read_fifo_flag,
        input  tx,
        input  tx_busy
    );

    modport slave (
        input  din,
        input  wr_en,
        output read_fifo_flag,
        output tx,
        output tx_busy
    );
endinterface

// File: rtl/dds_sine_lut.sv
// Full-wave 8-bit sine sample built from the quarter-wave table by symmetry folding.
module dds_sine_lut
    import dds_uart_pkg::*;
(
    input  logic [7:0] addr,
    output logic [7:0] sample
);

    logic [1:0] quadrant;
    logic [5:0] idx;
    logic [6:0] mirror;
    logic [7:0] mag;

    assign quadrant = addr[7:6];
    assign idx      = addr[5:0];
    assign mirror   = 7'(DDS_QUARTER) - {1'b0, idx};

    // Odd quadrants read the table backwards; the lower half-cycle reflects about mid-scale.
    always_comb begin
        mag    = quadrant[0] ? quarter_sample(mirror) : quarter_sample({1'b0, idx});
        sample = quadrant[1] ? 8'(9'd256 - {1'b0, mag}) : mag;
    end

endmodule

// File: rtl/dds_uart_tx_core.sv
// Baud ticks, FIFO-fed UART transmitter and 32-bit DDS I/Q sine source.
// Define UART_TX_PARITY_EN for an even-parity bit between data and stop (11-bit frame).
//
// state     | meaning
// TX_IDLE   | line high, waiting for a byte on a baud tick
// TX_START  | start bit (low)
// TX_DATA   | eight data bits, LSB first
// TX_PARITY | even parity bit (parity build only)
// TX_STOP   | stop bit (high); may chain straight into the next start bit
module dds_uart_tx_core
    import dds_uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic              clk_50m,
    input  logic              reset,
    input  logic [31:0]       freq_tuning_word,
    input  logic              phase_accumulator_reset,
    output logic [7:0]        dac_data,
    output logic [7:0]        q_dac_data,
    output logic              txclk_en,
    output logic              rxclk_en,
    dds_uart_tx_core_if.slave fifo
);

    localparam int TX_DIV   = CLK_FREQ / BAUD;
    localparam int RX_DIV   = CLK_FREQ / (BAUD * 16);
    localparam int TX_CNT_W = $clog2(TX_DIV);
    localparam int RX_CNT_W = $clog2(RX_DIV);

    logic [TX_CNT_W-1:0] tx_cnt;
    logic [RX_CNT_W-1:0] rx_cnt;

    assign txclk_en = (tx_cnt == TX_CNT_W'(TX_DIV - 1));
    assign rxclk_en = (rx_cnt == RX_CNT_W'(RX_DIV - 1));

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            tx_cnt <= '0;
            rx_cnt <= '0;
        end else begin
            tx_cnt <= txclk_en ? '0 : tx_cnt + TX_CNT_W'(1);
            rx_cnt <= rxclk_en ? '0 : rx_cnt + RX_CNT_W'(1);
        end
    end

    tx_state_t  state, state_nxt;
    logic [7:0] data_q, data_nxt;
    logic [2:0] bit_idx, bit_nxt;
    logic       tx_q, tx_nxt;
    logic       pop;

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            state   <= TX_IDLE;
            data_q  <= '0;
            bit_idx <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_nxt;
            data_q  <= data_nxt;
            bit_idx <= bit_nxt;
            tx_q    <= tx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        data_nxt  = data_q;
        bit_nxt   = bit_idx;
        tx_nxt    = tx_q;
        pop       = 1'b0;
        if (txclk_en) begin
            case (state)
                // End of stop bit behaves like idle so a waiting byte chains with no gap.
                TX_IDLE, TX_STOP: begin
                    tx_nxt    = 1'b1;
                    state_nxt = TX_IDLE;
                    if (fifo.wr_en) begin
                        pop       = 1'b1;
                        data_nxt  = fifo.din;
                        tx_nxt    = 1'b0;
                        state_nxt = TX_START;
                    end
                end
                TX_START: begin
                    tx_nxt    = data_q[0];
                    bit_nxt   = 3'd0;
                    state_nxt = TX_DATA;
                end
                TX_DATA: begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_nxt    = ^data_q;
                        state_nxt = TX_PARITY;
`else
                        tx_nxt    = 1'b1;
                        state_nxt = TX_STOP;
`endif
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                        tx_nxt  = data_q[bit_idx + 3'd1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                TX_PARITY: begin
                    tx_nxt    = 1'b1;
                    state_nxt = TX_STOP;
                end
`endif
                default: begin
                    tx_nxt    = 1'b1;
                    state_nxt = TX_IDLE;
                end
            endcase
        end
    end

    assign fifo.tx             = tx_q;
    assign fifo.tx_busy        = (state != TX_IDLE);
    assign fifo.read_fifo_flag = pop & ~reset;

    logic [31:0] phase_acc;
    logic [7:0]  addr_i, addr_q;
    logic [7:0]  lut_i, lut_q;

    assign addr_i = phase_acc[31:24];
    assign addr_q = addr_i + 8'(DDS_QUARTER);

    dds_sine_lut u_lut_i (.addr(addr_i), .sample(lut_i));
    dds_sine_lut u_lut_q (.addr(addr_q), .sample(lut_q));

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            phase_acc  <= '0;
            dac_data   <= DAC_MID;
            q_dac_data <= DAC_PEAK;
        end else begin
            phase_acc  <= phase_accumulator_reset ? '0 : phase_acc + freq_tuning_word;
            dac_data   <= lut_i;
            q_dac_data <= lut_q;
        end
    end

endmodule

// File: tb/tb_dds_uart_tx_core.sv
// Self-checking bench: DDS vector table, baud tick timing, UART frames via a bit scoreboard.
module tb_dds_uart_tx_core;

    localparam int TX_DIV = 434;
    localparam int RX_DIV = 27;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic        clk_50m = 1'b0;
    logic        reset   = 1'b1;
    logic [31:0] ftw     = 32'h0;
    logic        par_rst = 1'b0;
    logic [7:0]  dac_data, q_dac_data;
    logic        txclk_en, rxclk_en;

    dds_uart_tx_core_if fifo_if ();

    dds_uart_tx_core dut (
        .clk_50m                 (clk_50m),
        .reset                   (reset),
        .freq_tuning_word        (ftw),
        .phase_accumulator_reset (par_rst),
        .dac_data                (dac_data),
        .q_dac_data              (q_dac_data),
        .txclk_en                (txclk_en),
        .rxclk_en                (rxclk_en),
        .fifo                    (fifo_if)
    );

    always #10 clk_50m = ~clk_50m;

    typedef struct {
        logic [31:0] ftw;
        logic        par;
        logic [7:0]  exp_i;
        logic [7:0]  exp_q;
    } dds_vec_t;

    dds_vec_t   vecs [20];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         pop_cnt  = 0;
    logic [7:0] fifo_q [$];
    logic       exp_bits [$];
    logic       line_tx   = 1'b1;
    logic       line_busy = 1'b0;
    bit         mon_en      = 1'b0;
    bit         popped_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic push_frame(input logic [7:0] b);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        exp_bits.push_back(^b);
`endif
        exp_bits.push_back(1'b1);
    endtask

    // One clock: FIFO model drive, pop capture, and tx/tx_busy scoreboard at each baud tick.
    task automatic cyc();
        @(negedge clk_50m);
        if (popped_prev) begin
            void'(fifo_q.pop_front());
            popped_prev = 1'b0;
        end
        fifo_if.wr_en = (fifo_q.size() != 0);
        fifo_if.din   = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        #1;
        if (fifo_if.read_fifo_flag) begin
            pop_cnt++;
            push_frame(fifo_if.din);
            popped_prev = 1'b1;
        end
        if (mon_en && txclk_en) begin
            check("tx_line{tx,busy}", {30'd0, fifo_if.tx, fifo_if.tx_busy}, {30'd0, line_tx, line_busy});
            if (exp_bits.size() != 0) begin
                line_tx   = exp_bits.pop_front();
                line_busy = 1'b1;
            end else begin
                line_tx   = 1'b1;
                line_busy = 1'b0;
            end
        end
    endtask

    task automatic monitor_restart();
        exp_bits.delete();
        fifo_q.delete();
        popped_prev = 1'b0;
        line_tx     = 1'b1;
        line_busy   = 1'b0;
    endtask

    task automatic measure_frames(input string nm, input int nbytes);
        int n, run, p0;
        p0 = pop_cnt;
        n  = 0;
        while (fifo_if.tx_busy !== 1'b1 && n < 2 * TX_DIV + 20) begin
            cyc();
            n++;
        end
        check({nm, "_start"}, {31'd0, fifo_if.tx_busy}, 32'd1);
        run = 0;
        while (fifo_if.tx_busy === 1'b1 && run < 4 * FRAME_BITS * TX_DIV) begin
            cyc();
            run++;
        end
        check({nm, "_busy_len"}, run, nbytes * FRAME_BITS * TX_DIV);
        check({nm, "_pops"}, pop_cnt - p0, nbytes);
        for (int i = 0; i < 2 * TX_DIV; i++) cyc();
    endtask

    initial begin
        int tx_first, rx_first, last_tx, last_rx, ntx, nrx;

        vecs[0]  = '{32'h0000_0000, 1'b0, 8'd128, 8'd255};
        vecs[1]  = '{32'h0000_0000, 1'b0, 8'd128, 8'd255};
        vecs[2]  = '{32'h4000_0000, 1'b0, 8'd128, 8'd255};
        vecs[3]  = '{32'h4000_0000, 1'b0, 8'd255, 8'd128};
        vecs[4]  = '{32'h4000_0000, 1'b0, 8'd128, 8'd1};
        vecs[5]  = '{32'h4000_0000, 1'b0, 8'd1,   8'd128};
        vecs[6]  = '{32'h4000_0000, 1'b0, 8'd128, 8'd255};
        vecs[7]  = '{32'h0000_0000, 1'b0, 8'd255, 8'd128};
        vecs[8]  = '{32'h0000_0000, 1'b0, 8'd255, 8'd128};
        vecs[9]  = '{32'h4000_0000, 1'b1, 8'd255, 8'd128};
        vecs[10] = '{32'h0000_0000, 1'b0, 8'd128, 8'd255};
        vecs[11] = '{32'h0000_0000, 1'b0, 8'd128, 8'd255};
        vecs[12] = '{32'h2000_0000, 1'b0, 8'd128, 8'd255};
        vecs[13] = '{32'h2000_0000, 1'b0, 8'd218, 8'd218};
        vecs[14] = '{32'h2000_0000, 1'b0, 8'd255, 8'd128};
        vecs[15] = '{32'h2000_0000, 1'b0, 8'd218, 8'd38};
        vecs[16] = '{32'h2000_0000, 1'b0, 8'd128, 8'd1};
        vecs[17] = '{32'h2000_0000, 1'b0, 8'd38,  8'd38};
        vecs[18] = '{32'hFFFF_FFFF, 1'b0, 8'd1,   8'd128};
        vecs[19] = '{32'h0000_0000, 1'b0, 8'd1,   8'd125};

        fifo_if.wr_en = 1'b0;
        fifo_if.din   = 8'h00;
        for (int i = 0; i < 10; i++) cyc();
        check("rst_tx", {31'd0, fifo_if.tx}, 32'd1);
        check("rst_busy", {31'd0, fifo_if.tx_busy}, 32'd0);
        check("rst_pop", {31'd0, fifo_if.read_fifo_flag}, 32'd0);
        check("rst_txclk_en", {31'd0, txclk_en}, 32'd0);
        check("rst_rxclk_en", {31'd0, rxclk_en}, 32'd0);
        check("rst_dac", {24'd0, dac_data}, 32'd128);
        check("rst_qdac", {24'd0, q_dac_data}, 32'd255);

        monitor_restart();
        mon_en = 1'b1;
        reset  = 1'b0;

        tx_first = 0; rx_first = 0; last_tx = 0; last_rx = 0; ntx = 0; nrx = 0;
        for (int n = 1; n <= 3 * TX_DIV + 100; n++) begin
            if (txclk_en) begin
                if (tx_first == 0) tx_first = n;
                else if (ntx < 2) begin
                    check("txclk_period", n - last_tx, TX_DIV);
                    ntx++;
                end
                last_tx = n;
            end
            if (rxclk_en) begin
                if (rx_first == 0) rx_first = n;
                else if (nrx < 3) begin
                    check("rxclk_period", n - last_rx, RX_DIV);
                    nrx++;
                end
                last_rx = n;
            end
            cyc();
        end
        check("txclk_first", tx_first, TX_DIV);
        check("rxclk_first", rx_first, RX_DIV);
        check("txclk_periods_seen", ntx, 2);

        for (int v = 0; v < 20; v++) begin
            ftw     = vecs[v].ftw;
            par_rst = vecs[v].par;
            cyc();
            check($sformatf("dds_i[%0d]", v), {24'd0, dac_data}, {24'd0, vecs[v].exp_i});
            check($sformatf("dds_q[%0d]", v), {24'd0, q_dac_data}, {24'd0, vecs[v].exp_q});
        end
        ftw     = 32'h0;
        par_rst = 1'b0;

        fifo_q.push_back(8'hA5);
        measure_frames("frame_a5", 1);

        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        fifo_q.push_back(8'h55);
        measure_frames("b2b3", 3);

        fifo_q.push_back(8'h07);
        measure_frames("frame_07", 1);
        check("scoreboard_drained", exp_bits.size(), 0);
        check("fifo_drained", fifo_q.size(), 0);

        mon_en = 1'b0;
        fifo_q.push_back(8'h07);
        for (int n = 0; n < 2 * TX_DIV + 20 && fifo_if.tx_busy !== 1'b1; n++) cyc();
        for (int n = 0; n < 5 * TX_DIV + 200; n++) cyc();
        check("mid_busy", {31'd0, fifo_if.tx_busy}, 32'd1);
        check("mid_tx_low", {31'd0, fifo_if.tx}, 32'd0);
        reset = 1'b1;
        cyc();
        check("midrst_tx", {31'd0, fifo_if.tx}, 32'd1);
        check("midrst_busy", {31'd0, fifo_if.tx_busy}, 32'd0);
        check("midrst_pop", {31'd0, fifo_if.read_fifo_flag}, 32'd0);
        check("midrst_dac", {24'd0, dac_data}, 32'd128);
        check("midrst_qdac", {24'd0, q_dac_data}, 32'd255);
        cyc();
        monitor_restart();
        mon_en = 1'b1;
        reset  = 1'b0;
        for (int n = 0; n < 2 * TX_DIV + 10; n++) cyc();
        check("post_idle_tx", {31'd0, fifo_if.tx}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
